// File: rtl/mu0_alu_pkg.sv
// Shared types and constants for the MU0 bit-serial add/subtract unit.
// The optional overflow flag is controlled by MU0_SERIAL_ALU_OVF_EN.
package mu0_alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MU0_WIDTH = 16;

endpackage

// File: rtl/mu0_serial_slice.sv
// Single full-adder slice; binv inverts b so that a + ~b + 1 yields a - b.
module mu0_serial_slice (
    input  logic a,
    input  logic b,
    input  logic binv,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic b_eff;

    assign b_eff = b ^ binv;
    assign sum   = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/mu0_serial_alu.sv
// Bit-serial WIDTH-bit add/subtract unit, LSB first, start/done handshake.
// Define MU0_SERIAL_ALU_OVF_EN to add the signed-overflow flag output ovf.
module mu0_serial_alu
    import mu0_alu_pkg::*;
#(
    parameter int WIDTH = MU0_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
`ifdef MU0_SERIAL_ALU_OVF_EN
    output logic             neg,
    output logic             ovf
`else
    output logic             neg
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    alu_state_t       state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg, res_shift;
    logic [CW-1:0]    cnt_reg;
    logic             binv_reg, carry_reg;
    logic             slice_sum, slice_cout;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg, zero_reg, neg_reg;
    logic             last_shift;

    mu0_serial_slice u_slice (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .binv (binv_reg),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign res_shift  = {slice_sum, res_sr_reg[WIDTH-1:1]};
    assign last_shift = (state_reg == SHIFT) && (cnt_reg == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            cnt_reg    <= '0;
            binv_reg   <= 1'b0;
            carry_reg  <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                a_sr_reg  <= a;
                b_sr_reg  <= b;
                binv_reg  <= (op == OP_SUB);
                carry_reg <= (op == OP_SUB);
                cnt_reg   <= CW'(WIDTH - 1);
            end
        end else if (state_reg == SHIFT) begin
            a_sr_reg   <= a_sr_reg >> 1;
            b_sr_reg   <= b_sr_reg >> 1;
            res_sr_reg <= res_shift;
            carry_reg  <= slice_cout;
            cnt_reg    <= cnt_reg - 1'b1;
        end
    end

    // Flags come from the completed word so they never show a partial shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_reg <= '0;
            cout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
        end else if (last_shift) begin
            result_reg <= res_shift;
            cout_reg   <= slice_cout;
            zero_reg   <= (res_shift == '0);
            neg_reg    <= res_shift[WIDTH-1];
        end
    end

`ifdef MU0_SERIAL_ALU_OVF_EN
    logic cmsb_reg;

    // During the final shift the carry register holds the carry into the MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmsb_reg <= 1'b0;
        end else if (last_shift) begin
            cmsb_reg <= carry_reg;
        end
    end

    assign ovf = cmsb_reg ^ cout_reg;
`endif

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign cout   = cout_reg;
    assign zero   = zero_reg;
    assign neg    = neg_reg;

endmodule

// File: tb/tb_mu0_serial_alu.sv
// Self-checking bench for mu0_serial_alu: directed vector table, hand-written
// multi-cycle sequences and randomized operations against an arithmetic model.
module tb_mu0_serial_alu;
    import mu0_alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n, start, op;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, zero, neg;
`ifdef MU0_SERIAL_ALU_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    mu0_serial_alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .zero    (zero),
`ifdef MU0_SERIAL_ALU_OVF_EN
        .neg     (neg),
        .ovf     (ovf)
`else
        .neg     (neg)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] prev_result;

    typedef struct {
        logic         o;
        logic [W-1:0] x, y, r;
        logic         c, z, n, v;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic z,
                         output logic n, output logic v);
        int sa, sb, s;
        logic [W:0] wide;
        sa = int'($signed(x));
        sb = int'($signed(y));
        if (o == OP_ADD) begin
            wide = {1'b0, x} + {1'b0, y};
            r = wide[W-1:0];
            c = wide[W];
            s = sa + sb;
        end else begin
            r = x - y;
            c = (x >= y);
            s = sa - sb;
        end
        z = (r == '0);
        n = r[W-1];
        v = (s > 32767) || (s < -32768);
    endtask

    function automatic logic get_ovf();
`ifdef MU0_SERIAL_ALU_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic do_op(input string tag, input logic o, input logic [W-1:0] x,
                         input logic [W-1:0] y, output logic [W-1:0] r, output logic c,
                         output logic z, output logic n, output logic v);
        int cyc;
        int gaps;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        cyc = 1; gaps = 0;
        start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
        while (!done && cyc < 40) begin
            if (!busy) gaps++;
            if (cyc == 8) check({tag, " hold"}, 32'(result), 32'(prev_result));
            @(posedge clk); #1;
            cyc++;
            a = W'($urandom); b = W'($urandom);
        end
        check({tag, " latency"}, cyc, W + 1);
        check({tag, " busy"}, {gaps[30:0], busy}, 32'd1);
        r = result; c = cout; z = zero; n = neg; v = get_ovf();
        @(posedge clk); #1;
        check({tag, " pulse"}, {busy, done}, 32'd0);
        $display("op %s %0d a=%h b=%h -> %h c%0d z%0d n%0d v%0d lat %0d",
                 tag, o, x, y, r, c, z, n, v, cyc);
    endtask

    task automatic compare(input string tag, input vec_t e, input logic [W-1:0] r,
                           input logic c, input logic z, input logic n, input logic v);
        check({tag, " result"}, 32'(r), 32'(e.r));
        check({tag, " flags"}, {c, z, n}, {e.c, e.z, e.n});
`ifdef MU0_SERIAL_ALU_OVF_EN
        check({tag, " ovf"}, 32'(v), 32'(e.v));
`else
        if (v !== 1'b0) check({tag, " ovf"}, 32'(v), 32'd0);
`endif
    endtask

    initial begin
        logic [W-1:0] r;
        logic         c, z, n, v;
        vec_t         e;
        int           d1, d2;

        vecs[0] = '{OP_ADD, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{OP_SUB, 16'h1234, 16'h4321, 16'hCF13, 1'b0, 1'b0, 1'b1, 1'b0};

        reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #3;
        check("reset outputs", {busy, done, cout, zero, neg, get_ovf(), result}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", {busy, done, result}, 32'd0);
        prev_result = '0;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].x, vecs[i].y, r, c, z, n, v);
            compare($sformatf("vec%0d", i), vecs[i], r, c, z, n, v);
            prev_result = vecs[i].r;
            if (i == 3) begin
                repeat (3) @(posedge clk);
                #1 check("idle hold", {busy, done, 16'h0, result}, {2'b00, 16'h0, prev_result});
            end
        end

        // Start held high with changing operands: only the accepting cycle counts.
        start = 1'b1; op = OP_SUB; a = 16'h1000; b = 16'h0001;
        d1 = 0; d2 = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 18) begin
                op = OP_ADD; a = 16'h0100; b = 16'h0023;
            end else begin
                op = 1'($urandom); a = W'($urandom); b = W'($urandom);
            end
            if (done && d1 == 0) begin
                d1 = cyc;
                check("held first result", 32'(result), 32'h0FFF);
            end else if (done) begin
                d2 = cyc;
                check("held second result", 32'(result), 32'h0123);
                break;
            end
        end
        start = 1'b0;
        check("held first done cycle", d1, 17);
        check("held second done cycle", d2, 35);
        $display("op held-start done cycles %0d and %0d", d1, d2);
        @(posedge clk); #1;
        prev_result = 16'h0123;

        // Reset in the middle of an operation.
        model(OP_ADD, 16'hFFFF, 16'h8001, e.r, e.c, e.z, e.n, e.v);
        do_op("pre-reset", OP_ADD, 16'hFFFF, 16'h8001, r, c, z, n, v);
        compare("pre-reset", e, r, c, z, n, v);
        prev_result = e.r;
        start = 1'b1; op = OP_ADD; a = 16'h1111; b = 16'h2222;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check("mid-op reset", {busy, done, cout, zero, neg, get_ovf(), result}, 32'd0);
        @(posedge clk); #1;
        check("held in reset", {busy, done, result}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        prev_result = '0;
        e = '{OP_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0};
        do_op("post-reset", OP_ADD, 16'h0002, 16'h0003, r, c, z, n, v);
        compare("post-reset", e, r, c, z, n, v);
        prev_result = e.r;

        for (int i = 0; i < 40; i++) begin
            logic         ro;
            logic [W-1:0] rx, ry;
            ro = 1'($urandom);
            rx = W'($urandom);
            ry = (i % 8 == 0) ? rx : W'($urandom);
            model(ro, rx, ry, e.r, e.c, e.z, e.n, e.v);
            do_op($sformatf("rnd%0d", i), ro, rx, ry, r, c, z, n, v);
            compare($sformatf("rnd%0d", i), e, r, c, z, n, v);
            prev_result = e.r;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mu0_serial_alu.md
# mu0_serial_alu

Bit-serial 16-bit add/subtract unit for the MU0 datapath. It evaluates one bit position per clock through a single full-adder slice with a registered carry. It trades a WIDTH-cycle latency for one slice of logic. The control unit launches it with a start/done handshake for ADD and SUB instructions, and it returns the result plus condition flags.

## Interface
- WIDTH, 16, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  launch request; sampled only in IDLE
- op  in  1  0 = ADD (a+b), 1 = SUB (a−b)
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; result and flags are valid
- result  out  WIDTH  sum or difference
- cout  out  1  final carry; for SUB, 1 = no borrow
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- ovf  out  1  signed overflow; present only with MU0_SERIAL_ALU_OVF_EN

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - latch a and b into shift registers; latch op as binv.
  - load carry register with op (cin=1 for SUB).
  - load bit counter with WIDTH−1; go to SHIFT.
- IDLE, start=0: hold all outputs.
- SHIFT, each cycle:
  - slice inputs: a_sr[0], b_sr[0]^binv, carry.
  - sum bit shifts into result_sr[WIDTH-1]; result_sr shifts right.
  - a_sr and b_sr shift right; carry register ← slice cout.
  - counter decrements; at counter==0 go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- result, cout, zero and neg update together on the last SHIFT edge. They hold until the last SHIFT edge of the next operation.
- zero and neg are registered from the completed result, not from the partial shift register.
- start is ignored in SHIFT and DONE; there is no queueing. op, a and b are don't-care outside the accepting cycle.
- Reset value of every output: 0. State resets to IDLE; shift registers, counter and carry reset to 0.
- Reset asserted mid-operation aborts immediately. The previous result is lost. The next start after release behaves normally.

## Timing
- start high in cycle 0 (IDLE) is accepted at the edge ending cycle 0.
- busy is high in cycles 1..WIDTH+1.
- SHIFT occupies cycles 1..WIDTH.
- done is high in cycle WIDTH+1 only; result and flags are valid from that cycle.
- The next start is accepted in cycle WIDTH+2 at the earliest. Throughput is one operation per WIDTH+2 cycles.
- Every register sits on the clk edge or the async reset. No combinational path from inputs to outputs.

## Configuration
- MU0_SERIAL_ALU_OVF_EN defined:
  - a register captures the carry into the MSB during the final SHIFT cycle.
  - ovf = carry_into_msb ^ cout, updated alongside the other flags; reset 0.
- Not defined: the ovf port, the capture register and its logic are absent. All other behaviour is identical.

## Structure
- Package mu0_alu_pkg holds:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - op encoding constants (OP_ADD=1'b0, OP_SUB=1'b1);
  - default width constant MU0_WIDTH=16.
- One sub-module, mu0_serial_slice, is combinational and computes sum and cout:
  - inputs a, b, binv, cin;
  - outputs sum, cout.
- The FSM, counter, shift registers and flag registers live in mu0_serial_alu.

## Test plan
- ADD a=0x1234, b=0x0001 → result 0x1235, cout 0, zero 0, neg 0; done exactly in cycle 17 and only for that cycle.
- SUB a=0x0005, b=0x0005 → result 0x0000, zero 1, cout 1. SUB a=0x0000, b=0x0001 → result 0xFFFF, cout 0, neg 1.
- ADD a=0xFFFF, b=0x0001 → result 0x0000, cout 1, zero 1. With MU0_SERIAL_ALU_OVF_EN: ADD 0x7FFF+0x0001 → 0x8000, ovf 1. SUB 0x8000−0x0001 → 0x7FFF, ovf 1.
- Hold start high with changing operands through the whole operation → only the cycle-0 operands are used. A second operation is accepted in cycle 18 and its done appears in cycle 35.
- Assert reset_n low in cycle 8 of an operation → busy, done, result and all flags are 0 immediately. After release, ADD 0x0002+0x0003 → 0x0005 with normal latency.
